// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus used by the fetch stage.
//   req    : fetch request (master -> slave), held until gnt
//   addr   : word address of the request
//   gnt    : request accepted this cycle
//   rvalid : response valid, in order, at least one cycle after gnt
//   rdata  : returned instruction word
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, issues one word request at a time to
// instruction memory, buffers returned words in a small FIFO and presents
// {inst, inst_addr} pairs to the decode side. A jump redirects the PC, flushes
// the buffer and drops the response still in flight for the old path.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   jump_ena_i    redirect request from ex
//   jump_addr_i   redirect target
//   hold_i        downstream stall: head entry is not consumed
//   imem          instruction-memory bus (master side)
//   inst_o        instruction word (NOP when nothing valid)
//   inst_addr_o   address of inst_o (0 when nothing valid)
//   inst_valid_o  inst_o/inst_addr_o carry a fetched instruction
//   misalign_o    only with IF_MISALIGN_CHK_EN: sticky flag for a jump target
//                 with nonzero low bits; fetch halts until reset
//
// Build option: define IF_MISALIGN_CHK_EN to add the misaligned-target check.
// Without it the two low target bits are ignored.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_ena_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              hold_i,
  if_fetch_if.master        imem,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o,
  output logic              inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]     pc_q, pc_d;
  logic            out_q, out_d;          // one request in flight
  logic            discard_q, discard_d;  // next response belongs to a flushed path
  logic [31:0]     req_addr_q, req_addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];
  logic [31:0]     fifo_addr_q [FIFO_DEPTH];

  logic        halted;
  logic        jump_bad;
  logic [31:0] jump_target;
  logic [31:0] fill;
  logic        req;
  logic        handshake;
  logic        rsp;
  logic        push;
  logic        pop;
  logic        valid;

`ifdef IF_MISALIGN_CHK_EN
  logic halt_q, halt_d;
  assign halted     = halt_q;
  assign jump_bad   = (jump_addr_i[1:0] != 2'b00);
  assign misalign_o = halt_q;
`else
  assign halted   = 1'b0;
  assign jump_bad = 1'b0;
`endif

  assign jump_target = jump_addr_i & 32'hFFFF_FFFC;

  always_comb begin
    fill      = 32'(cnt_q) + 32'(out_q);
    // A response arriving this cycle frees the single outstanding slot.
    req       = !rst && !jump_ena_i && !halted && (!out_q || imem.rvalid) &&
                (fill < FIFO_DEPTH);
    handshake = req && imem.gnt;
    // Stray rvalid with nothing outstanding (e.g. just after reset) is ignored.
    rsp       = imem.rvalid && out_q;
    push      = rsp && !discard_q && !jump_ena_i;
    valid     = (cnt_q != '0) && !jump_ena_i;
    pop       = valid && !hold_i;
  end

  assign imem.req     = req;
  assign imem.addr    = pc_q;
  assign inst_valid_o = valid;
  assign inst_o       = valid ? fifo_inst_q[rd_ptr_q] : Nop;
  assign inst_addr_o  = valid ? fifo_addr_q[rd_ptr_q] : 32'h0;

  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q;
    discard_d  = discard_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (jump_ena_i) begin
      if (!jump_bad && !halted) pc_d = jump_target;
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end

    if (handshake) begin
      out_d      = 1'b1;
      req_addr_d = pc_q;
    end else if (rsp) begin
      out_d = 1'b0;
    end

    // Any response consumes the discard mark; a jump with a response still
    // pending marks it, and repeated jumps keep at most one mark.
    if (rsp) begin
      discard_d = 1'b0;
    end else if (jump_ena_i && out_q) begin
      discard_d = 1'b1;
    end

    if (jump_ena_i) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  always_comb begin
    halt_d = halt_q || (jump_ena_i && jump_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_q      <= 1'b0;
      discard_q  <= 1'b0;
      req_addr_q <= RESET_PC;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= imem.rdata;
      fifo_addr_q[wr_ptr_q] <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [31:0] jaddr = 32'h0;
  logic        hold = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_if imem_bus ();

  if_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_ena_i  (jump),
    .jump_addr_i (jaddr),
    .hold_i      (hold),
    .imem        (imem_bus),
    .inst_o      (inst),
    .inst_addr_o (inst_addr),
    .inst_valid_o(inst_valid)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .misalign_o  (misalign)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  // Memory and stream reference model state
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_wait;
  logic [31:0] exp_next;
  int          consumed;
  logic        prev_req, prev_gnt, prev_jump, prev_valid, prev_hold;
  logic [31:0] prev_addr, prev_iaddr, prev_inst;

  task automatic clear_inputs();
    jump = 1'b0; jaddr = 32'h0; hold = 1'b0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
  endtask

  // Leaves the bench at posedge+1 with reset released and the model cleared.
  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mem_pend = 1'b0; mem_wait = 0; mem_addr = 32'h0;
    exp_next = RESET_PC;
    prev_req = 0; prev_gnt = 0; prev_jump = 0; prev_valid = 0; prev_hold = 0;
    prev_addr = 0; prev_iaddr = 0; prev_inst = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Randomized traffic: memory model responds in order, the reference expects
  // a consecutive address stream restarted at every jump target.
  task automatic run_traffic(input int n, input int gnt_pct, input int hold_pct,
                             input int jump_pct, input int max_wait, output int grants);
    logic deliver;
    grants = 0;
    for (int c = 0; c < n; c++) begin
      deliver = mem_pend && (mem_wait == 0);
      imem_bus.rvalid = deliver;
      imem_bus.rdata  = deliver ? mk_data(mem_addr) : $urandom();
      imem_bus.gnt    = int'($urandom_range(99)) < gnt_pct;
      hold            = int'($urandom_range(99)) < hold_pct;
      jump            = int'($urandom_range(99)) < jump_pct;
      if ($urandom_range(3) == 0) jaddr = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3));
      else                        jaddr = $urandom() & 32'hFFFF_FFFC;
      @(negedge clk);
      if (prev_req && !prev_gnt && !prev_jump && !jump) begin
        check("req_held", 32'(imem_bus.req), 32'd1);
        check("addr_held", imem_bus.addr, prev_addr);
      end
      if (prev_valid && prev_hold && !prev_jump && !jump) begin
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_iaddr", inst_addr, prev_iaddr);
        check("hold_inst", inst, prev_inst);
      end
      if (jump) begin
        check("jump_valid", 32'(inst_valid), 32'd0);
        check("jump_req", 32'(imem_bus.req), 32'd0);
      end
      if (inst_valid && !hold) begin
        check("stream_addr", inst_addr, exp_next);
        check("stream_inst", inst, mk_data(exp_next));
        exp_next = exp_next + 32'd4;
        consumed++;
      end
      if (deliver) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (imem_bus.req && imem_bus.gnt) begin
        check("one_outstanding", 32'(mem_pend), 32'd0);
        grants++;
        mem_pend = 1'b1;
        mem_addr = imem_bus.addr;
        mem_wait = int'($urandom_range(max_wait));
      end
      if (jump) exp_next = jaddr & 32'hFFFF_FFFC;
      prev_req = imem_bus.req; prev_gnt = imem_bus.gnt; prev_jump = jump;
      prev_addr = imem_bus.addr; prev_valid = inst_valid; prev_hold = hold;
      prev_iaddr = inst_addr; prev_inst = inst;
      next_cycle();
    end
    clear_inputs();
  endtask

  typedef struct {
    logic        jump;
    logic [31:0] jaddr;
    logic        hold;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rv_addr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int g;
    int pre;
    // jump jaddr hold gnt rv rv_addr | req addr valid iaddr
    tbl[0]  = '{0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0};
    tbl[1]  = '{0, 32'h0,   0, 1, 1, 32'h0,   1, 32'h4,   0, 32'h0};
    tbl[2]  = '{0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0};
    tbl[3]  = '{0, 32'h0,   0, 0, 1, 32'h4,   1, 32'h8,   0, 32'h0};
    tbl[4]  = '{0, 32'h0,   1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h4};
    tbl[5]  = '{0, 32'h0,   1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4};
    tbl[6]  = '{0, 32'h0,   1, 1, 1, 32'h8,   0, 32'hC,   1, 32'h4};
    tbl[7]  = '{0, 32'h0,   1, 1, 0, 32'h0,   0, 32'hC,   1, 32'h4};
    tbl[8]  = '{0, 32'h0,   0, 1, 0, 32'h0,   0, 32'hC,   1, 32'h4};
    tbl[9]  = '{0, 32'h0,   0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8};
    tbl[10] = '{1, 32'h100, 0, 1, 0, 32'h0,   0, 32'h10,  0, 32'h0};
    tbl[11] = '{0, 32'h0,   0, 1, 1, 32'hC,   1, 32'h100, 0, 32'h0};
    tbl[12] = '{0, 32'h0,   0, 1, 1, 32'h100, 1, 32'h104, 0, 32'h0};
    tbl[13] = '{0, 32'h0,   1, 0, 0, 32'h0,   0, 32'h108, 1, 32'h100};
    tbl[14] = '{1, 32'h200, 0, 1, 1, 32'h104, 0, 32'h108, 0, 32'h0};
    tbl[15] = '{0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    tbl[16] = '{0, 32'h0,   0, 0, 1, 32'h200, 1, 32'h204, 0, 32'h0};
    tbl[17] = '{0, 32'h0,   0, 0, 0, 32'h0,   1, 32'h204, 1, 32'h200};

    consumed = 0;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_addr", imem_bus.addr, RESET_PC);
    check("rst_inst", inst, NOP);
    check("rst_iaddr", inst_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
`ifdef IF_MISALIGN_CHK_EN
    check("rst_misalign", 32'(misalign), 32'd0);
`endif

    // Directed cycle table: startup, full-FIFO hold, jump with discard, jump over hold
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      jump = tbl[i].jump; jaddr = tbl[i].jaddr; hold = tbl[i].hold;
      imem_bus.gnt    = tbl[i].gnt;
      imem_bus.rvalid = tbl[i].rvalid;
      imem_bus.rdata  = tbl[i].rvalid ? mk_data(tbl[i].rv_addr) : $urandom();
      @(negedge clk);
      check($sformatf("tbl%0d_req", i), 32'(imem_bus.req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), imem_bus.addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_iaddr", i), inst_addr, tbl[i].iaddr);
      check($sformatf("tbl%0d_inst", i), inst,
            tbl[i].valid ? mk_data(tbl[i].iaddr) : NOP);
      next_cycle();
    end

    // PC wrap at the top of the address space
    apply_reset();
    jump = 1'b1; jaddr = 32'hFFFF_FFFC;
    next_cycle();
    jump = 1'b0; imem_bus.gnt = 1'b1;
    @(negedge clk);
    check("wrap_req", 32'(imem_bus.req), 32'd1);
    check("wrap_addr_top", imem_bus.addr, 32'hFFFF_FFFC);
    next_cycle();
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = mk_data(32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr_zero", imem_bus.addr, 32'h0);
    next_cycle();
    imem_bus.rvalid = 1'b0;
    @(negedge clk);
    check("wrap_valid", 32'(inst_valid), 32'd1);
    check("wrap_iaddr", inst_addr, 32'hFFFF_FFFC);
    check("wrap_inst", inst, mk_data(32'hFFFF_FFFC));

`ifdef IF_MISALIGN_CHK_EN
    apply_reset();
    jump = 1'b1; jaddr = 32'h102;
    next_cycle();
    jump = 1'b0; imem_bus.gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mis_flag", 32'(misalign), 32'd1);
      check("mis_req", 32'(imem_bus.req), 32'd0);
      check("mis_valid", 32'(inst_valid), 32'd0);
      next_cycle();
    end
`else
    apply_reset();
    jump = 1'b1; jaddr = 32'h102;
    next_cycle();
    jump = 1'b0;
    @(negedge clk);
    check("lowbits_addr", imem_bus.addr, 32'h100);
`endif

    // Reset while a request is in flight; a late response must be ignored
    apply_reset();
    imem_bus.gnt = 1'b1;
    next_cycle();
    rst = 1'b1; imem_bus.gnt = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(imem_bus.req), 32'd0);
    check("midrst_addr", imem_bus.addr, RESET_PC);
    next_cycle();
    rst = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = mk_data(RESET_PC);
    @(negedge clk);
    check("midrst_req_after", 32'(imem_bus.req), 32'd1);
    check("midrst_addr_after", imem_bus.addr, RESET_PC);
    next_cycle();
    imem_bus.rvalid = 1'b0;
    @(negedge clk);
    check("midrst_no_stale", 32'(inst_valid), 32'd0);
    next_cycle();

    // Hold for 10 cycles with an always-granting, 1-cycle memory
    apply_reset();
    run_traffic(6, 100, 0, 0, 0, g);
    hold = 1'b1;
    run_traffic(10, 100, 100, 0, 0, g);
    check("hold_grants_le2", 32'(g <= 2), 32'd1);
    run_traffic(20, 100, 0, 0, 0, g);

    // Randomized traffic against the stream reference model
    apply_reset();
    pre = consumed;
    run_traffic(2500, 70, 25, 3, 2, g);
    run_traffic(500, 100, 0, 2, 0, g);
    check("progress", 32'((consumed - pre) >= 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
